// File: rtl/dwbuart_pkg.sv
// Shared types for the UART transmit path: scheduler state encoding and data width.
package dwbuart_pkg;
    localparam int TX_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        GUARD = 2'd2
    } tx_sched_state_t;
endpackage

// File: rtl/tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, naturally wrapping pointers, separate level counter.
// Head entry is presented combinationally on dout.
module tx_fifo
    import dwbuart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = TX_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LW-1:0]     level,
    output logic [LW-1:0]     level_nxt,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (level == '0);

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else
            level_nxt = level + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/tx_scheduler.sv
// Transmit scheduler: queues software bytes and launches one tx_frontend frame per byte.
// Optional inter-frame guard gap enabled by defining DWBUART_TX_GUARD_EN.
module tx_scheduler
    import dwbuart_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cr_en_i,
`ifdef DWBUART_TX_GUARD_EN
    input  logic [7:0]           cr_guard_i,
`endif
    input  logic                 flush_i,
    input  logic                 wr_i,
    input  logic [TX_DATA_W-1:0] wr_data_i,
    input  logic                 ovf_clr_i,
    output logic                 full_o,
    output logic [LW-1:0]        level_o,
    output logic                 tc_o,
    output logic                 ovf_o,
    output logic                 transmit_o,
    output logic [TX_DATA_W-1:0] dr_o,
    input  logic                 done_i
);
    tx_sched_state_t      state;
    tx_sched_state_t      state_nxt;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [TX_DATA_W-1:0] fifo_dout;
    logic [LW-1:0]        level_nxt;
    logic                 fifo_full;
    logic                 fifo_empty;
`ifdef DWBUART_TX_GUARD_EN
    logic [7:0]           guard_cnt;
`endif

    tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (TX_DATA_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .pop       (pop),
        .flush     (flush_i),
        .din       (wr_data_i),
        .dout      (fifo_dout),
        .level     (level_o),
        .level_nxt (level_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign full_o = fifo_full;

    // Launch decisions use the registered level, so a byte written into an empty FIFO waits a cycle.
    always_comb begin
        pop       = (state == IDLE) && cr_en_i && !fifo_empty && !flush_i;
        push      = wr_i && !flush_i && (!fifo_full || pop);
        drop      = wr_i && !flush_i && fifo_full && !pop;
        state_nxt = state;
        case (state)
            IDLE: if (pop) state_nxt = BUSY;
            BUSY: begin
                if (done_i)
                    state_nxt = IDLE;
`ifdef DWBUART_TX_GUARD_EN
                if (done_i && (cr_guard_i != 8'd0))
                    state_nxt = GUARD;
`endif
            end
`ifdef DWBUART_TX_GUARD_EN
            GUARD: if (guard_cnt <= 8'd1) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            transmit_o <= 1'b0;
            dr_o       <= '0;
            tc_o       <= 1'b1;
            ovf_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            transmit_o <= pop;
            if (pop)
                dr_o <= fifo_dout;
            tc_o <= (state_nxt == IDLE) && (level_nxt == '0) && !pop;
            if (drop)
                ovf_o <= 1'b1;
            else if (ovf_clr_i)
                ovf_o <= 1'b0;
        end
    end

`ifdef DWBUART_TX_GUARD_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            guard_cnt <= 8'd0;
        else if ((state == BUSY) && done_i)
            guard_cnt <= cr_guard_i;
        else if (state == GUARD)
            guard_cnt <= guard_cnt - 8'd1;
    end
`endif
endmodule

// File: tb/tb_tx_scheduler.sv
// Scenario bench for tx_scheduler with a queue of expected launch bytes.
// Guard-gap scenario is built when DWBUART_TX_GUARD_EN is defined.
module tb_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cr_en_i = 1'b0;
`ifdef DWBUART_TX_GUARD_EN
    logic [7:0]    cr_guard_i = 8'd0;
`endif
    logic          flush_i = 1'b0;
    logic          wr_i = 1'b0;
    logic [7:0]    wr_data_i = 8'd0;
    logic          ovf_clr_i = 1'b0;
    logic          full_o;
    logic [LW-1:0] level_o;
    logic          tc_o;
    logic          ovf_o;
    logic          transmit_o;
    logic [7:0]    dr_o;
    logic          done_i = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_launch = 0;
    logic [7:0] exp_q[$];

    tx_scheduler #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cr_en_i    (cr_en_i),
`ifdef DWBUART_TX_GUARD_EN
        .cr_guard_i (cr_guard_i),
`endif
        .flush_i    (flush_i),
        .wr_i       (wr_i),
        .wr_data_i  (wr_data_i),
        .ovf_clr_i  (ovf_clr_i),
        .full_o     (full_o),
        .level_o    (level_o),
        .tc_o       (tc_o),
        .ovf_o      (ovf_o),
        .transmit_o (transmit_o),
        .dr_o       (dr_o),
        .done_i     (done_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        if (transmit_o === 1'b1) n_launch++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic do_reset();
        rst_i = 1'b1; cr_en_i = 1'b0; flush_i = 1'b0; wr_i = 1'b0;
        ovf_clr_i = 1'b0; done_i = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_i = 1'b1;
        wr_data_i = b;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        @(negedge clk_i);
        wr_i = 1'b0;
    endtask

    task automatic done_pulse();
        done_i = 1'b1;
        @(negedge clk_i);
        done_i = 1'b0;
    endtask

    task automatic wait_launch(output bit ok, output logic [7:0] d, output int t);
        ok = 1'b0; d = 8'd0; t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (transmit_o === 1'b1) begin
                ok = 1'b1; d = dr_o; t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [LW+12:0] got, exp;
        do_reset();
        exp = {1'b1, LW'(0), 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            got = {tc_o, level_o, transmit_o, ovf_o, full_o, dr_o};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_state cyc%0d: got {tc,level,tx,ovf,full,dr}=%h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        do_reset();
        cr_en_i = 1'b1;
        write_byte(8'hA5);
        n_cmp++;
        if (tc_o !== 1'b0 || level_o !== LW'(1) || transmit_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after_write: tc=%b level=%0d tx=%b required tc=0 level=1 tx=0", tc_o, level_o, transmit_o);
        end
        @(negedge clk_i);
        e = exp_q.pop_front();
        n_cmp++;
        if (transmit_o !== 1'b1 || dr_o !== e) begin
            n_bad++;
            $display("FAIL single_launch: tx=%b dr=%h required tx=1 dr=%h", transmit_o, dr_o, e);
        end
        @(negedge clk_i);
        n_cmp++;
        if (transmit_o !== 1'b0 || dr_o !== e || tc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy: tx=%b dr=%h tc=%b required tx=0 dr=%h tc=0", transmit_o, dr_o, tc_o, e);
        end
        done_pulse();
        n_cmp++;
        if (tc_o !== 1'b1) begin
            n_bad++;
            $display("FAIL single_tc_rise: tc=%b required 1", tc_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [7:0] d, e; int t, t_done, base;
        do_reset();
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        cr_en_i = 1'b1;
        wait_launch(ok, d, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || d !== e) begin
            n_bad++;
            $display("FAIL b2b_launch0: ok=%b dr=%h required ok=1 dr=%h", ok, d, e);
        end
        for (int k = 1; k <= 3; k++) begin
            base = n_launch;
            repeat (39) @(negedge clk_i);
            n_cmp++;
            if (n_launch !== base) begin
                n_bad++;
                $display("FAIL b2b_busy_quiet%0d: launches=%0d required %0d", k, n_launch, base);
            end
            t_done = cyc;
            done_pulse();
            if (k < 3) begin
                wait_launch(ok, d, t);
                e = exp_q.pop_front();
                n_cmp++;
                if (!ok || d !== e || (t - t_done) !== 2) begin
                    n_bad++;
                    $display("FAIL b2b_launch%0d: ok=%b dr=%h gap=%0d required ok=1 dr=%h gap=2", k, ok, d, t - t_done, e);
                end
            end else begin
                n_cmp++;
                if (tc_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_tc: tc=%b required 1", tc_o);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok; logic [7:0] d, e; int t, base;
        do_reset();
        base = n_launch;
        for (int i = 0; i <= DEPTH; i++) write_byte(8'h10 + 8'(i));
        n_cmp++;
        if (full_o !== 1'b1 || level_o !== LW'(DEPTH) || ovf_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_full: full=%b level=%0d ovf=%b required full=1 level=%0d ovf=1", full_o, level_o, ovf_o, DEPTH);
        end
        wr_i = 1'b1; wr_data_i = 8'hEE; ovf_clr_i = 1'b1;
        @(negedge clk_i);
        wr_i = 1'b0; ovf_clr_i = 1'b0;
        n_cmp++;
        if (ovf_o !== 1'b1 || level_o !== LW'(DEPTH)) begin
            n_bad++;
            $display("FAIL ovf_drop_beats_clr: ovf=%b level=%0d required ovf=1 level=%0d", ovf_o, level_o, DEPTH);
        end
        ovf_clr_i = 1'b1;
        @(negedge clk_i);
        ovf_clr_i = 1'b0;
        n_cmp++;
        if (ovf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: ovf=%b required 0", ovf_o);
        end
        cr_en_i = 1'b1; wr_i = 1'b1; wr_data_i = 8'h77;
        exp_q.push_back(8'h77);
        @(negedge clk_i);
        wr_i = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (transmit_o !== 1'b1 || dr_o !== e || level_o !== LW'(DEPTH) || ovf_o !== 1'b0 || full_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_push_pop_full: tx=%b dr=%h level=%0d ovf=%b full=%b required tx=1 dr=%h level=%0d ovf=0 full=1",
                     transmit_o, dr_o, level_o, ovf_o, full_o, e, DEPTH);
        end
        done_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            wait_launch(ok, d, t);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL ovf_drain%0d: ok=%b dr=%h required ok=1 dr=%h", i, ok, d, e);
            end
            done_pulse();
        end
        repeat (20) @(negedge clk_i);
        n_cmp++;
        if ((n_launch - base) !== DEPTH + 1 || tc_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_total: launches=%0d tc=%b required launches=%0d tc=1", n_launch - base, tc_o, DEPTH + 1);
        end
    endtask

    task automatic test_flush();
        bit ok; logic [7:0] d, e; int t, base;
        do_reset();
        for (int i = 0; i < 4; i++) write_byte(8'h31 + 8'(i));
        cr_en_i = 1'b1;
        wait_launch(ok, d, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || d !== e || level_o !== LW'(3)) begin
            n_bad++;
            $display("FAIL flush_pre: ok=%b dr=%h level=%0d required ok=1 dr=%h level=3", ok, d, level_o, e);
        end
        flush_i = 1'b1; wr_i = 1'b1; wr_data_i = 8'h99;
        @(negedge clk_i);
        flush_i = 1'b0; wr_i = 1'b0;
        exp_q.delete();
        n_cmp++;
        if (level_o !== LW'(0) || ovf_o !== 1'b0 || full_o !== 1'b0 || tc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_level: level=%0d ovf=%b full=%b tc=%b required level=0 ovf=0 full=0 tc=0", level_o, ovf_o, full_o, tc_o);
        end
        base = n_launch;
        repeat (10) @(negedge clk_i);
        done_pulse();
        repeat (20) @(negedge clk_i);
        n_cmp++;
        if (n_launch !== base || tc_o !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_after_done: launches=%0d tc=%b required launches=%0d tc=1", n_launch, tc_o, base);
        end
    endtask

`ifdef DWBUART_TX_GUARD_EN
    task automatic test_guard();
        bit ok; logic [7:0] d, e; int t, t_done;
        do_reset();
        cr_guard_i = 8'd5;
        write_byte(8'hC1); write_byte(8'hC2); write_byte(8'hC3);
        cr_en_i = 1'b1;
        wait_launch(ok, d, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || d !== e) begin
            n_bad++;
            $display("FAIL guard_launch0: ok=%b dr=%h required ok=1 dr=%h", ok, d, e);
        end
        t_done = cyc;
        done_pulse();
        wait_launch(ok, d, t);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || d !== e || (t - t_done) !== 2 + 5) begin
            n_bad++;
            $display("FAIL guard_gap: ok=%b dr=%h gap=%0d required ok=1 dr=%h gap=%0d", ok, d, t - t_done, e, 2 + 5);
        end
        done_pulse();
        n_cmp++;
        if (tc_o !== 1'b0 || level_o !== LW'(1)) begin
            n_bad++;
            $display("FAIL guard_state: tc=%b level=%0d required tc=0 level=1", tc_o, level_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (tc_o !== 1'b1 || level_o !== LW'(0) || transmit_o !== 1'b0) begin
            n_bad++;
            $display("FAIL guard_reset: tc=%b level=%0d tx=%b required tc=1 level=0 tx=0", tc_o, level_o, transmit_o);
        end
        rst_i = 1'b0;
        cr_guard_i = 8'd0;
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
`ifdef DWBUART_TX_GUARD_EN
        test_guard();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
